temp_conv_sequencer: RTL and testbench

Multi-cycle sequenced Celsius-to-Fahrenheit converter for the Nexys A7 I2C temperature-sensor path. It computes f = (c*9)/5 + 32 on a single shared shift-add/restoring-divide datapath, under an FSM, instead of a fully combinational multiply/divide chain. It sits between the I2C sensor read logic (producer of 8-bit Celsius samples) and the display/UART consumers. Both sides use valid/ready handshakes.

---
 rtl/temp_conv_sequencer_pkg.sv | 20 ++
 rtl/temp_conv_sequencer_if.sv | 23 ++
 rtl/temp_conv_sequencer_div5_serial.sv | 67 ++++++
 rtl/temp_conv_sequencer.sv | 96 +++++++++
 tb/tb_temp_conv_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/temp_conv_sequencer_pkg.sv
// Shared state encoding and datapath constants for the Celsius-to-Fahrenheit sequencer.
package temp_conv_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      ADD  = 3'd3,
      OUT  = 3'd4
   } state_e;

   localparam int P_W       = 12;
   localparam int DIV_STEPS = 12;

   localparam logic [3:0]     DIVISOR     = 4'd5;
   localparam logic [P_W-1:0] OFFSET      = 12'd32;
   // The divider's iteration counter is loaded with this and counts down to zero.
   localparam logic [3:0]     DIV_TC_LOAD = 4'(DIV_STEPS - 1);

endpackage

// File: rtl/temp_conv_sequencer_if.sv
// Valid/ready sample and result handshake between sensor reader, sequencer and consumers.
interface temp_conv_sequencer_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] c_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] f_out;
   logic       f_ovf;
   logic       busy;

   modport master (
      output in_valid, c_in, out_ready,
      input  in_ready, out_valid, f_out, f_ovf, busy
   );

   modport slave (
      input  in_valid, c_in, out_ready,
      output in_ready, out_valid, f_out, f_ovf, busy
   );

endinterface

// File: rtl/temp_conv_sequencer_div5_serial.sv
// Restoring divide-by-5, one quotient bit per cycle, MSB first; start loads the dividend.
module temp_conv_sequencer_div5_serial
   import temp_conv_sequencer_pkg::*;
(
   input  logic           clk_100MHz,
   input  logic           reset,
   input  logic           start,
   input  logic [P_W-1:0] dividend,
   output logic           done,
   output logic [P_W-1:0] quotient
);

   logic [P_W-1:0] dvd_q, dvd_d;
   logic [P_W-1:0] quo_q, quo_d;
   logic [2:0]     rem_q, rem_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           run_q, run_d;
   logic [3:0]     trial;

   always_comb begin
      dvd_d = dvd_q;
      quo_d = quo_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      run_d = run_q;
      trial = {rem_q, dvd_q[P_W-1]};
      if (start) begin
         dvd_d = dividend;
         quo_d = '0;
         rem_d = '0;
         cnt_d = DIV_TC_LOAD;
         run_d = 1'b1;
      end else if (run_q) begin
         dvd_d = {dvd_q[P_W-2:0], 1'b0};
         // Remainder stays below 5, so 3 bits hold it after each restore.
         if (trial >= DIVISOR) begin
            rem_d = 3'(trial - DIVISOR);
            quo_d = {quo_q[P_W-2:0], 1'b1};
         end else begin
            rem_d = trial[2:0];
            quo_d = {quo_q[P_W-2:0], 1'b0};
         end
         if (cnt_q == 4'd0) run_d = 1'b0;
         else               cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         dvd_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         dvd_q <= dvd_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign done     = run_q && (cnt_q == 4'd0);
   assign quotient = quo_q;

endmodule

// File: rtl/temp_conv_sequencer.sv
// Sequenced f = (c*9)/5 + 32 on a shared shift-add / serial-divide datapath.
//  state | meaning
//  IDLE  | ready for a Celsius sample
//  MUL   | form c*9 (+2 when rounding), start divider
//  DIV   | 12 serial divide steps
//  ADD   | add offset, flag/clamp overflow, raise out_valid
//  OUT   | hold result until consumer takes it
module temp_conv_sequencer
   import temp_conv_sequencer_pkg::*;
#(
   parameter bit ROUND    = 1'b0,
   parameter bit SATURATE = 1'b1
) (
   input logic                  clk_100MHz,
   input logic                  reset,
   temp_conv_sequencer_if.slave bus
);

   state_e         state_q, state_d;
   logic [7:0]     c_q, c_d;
   logic [7:0]     f_out_q, f_out_d;
   logic           f_ovf_q, f_ovf_d;
   logic           out_valid_q, out_valid_d;
   logic           div_start;
   logic           div_done;
   logic [P_W-1:0] div_quo;
   logic [P_W-1:0] prod;
   logic [P_W-1:0] sum;
   logic           ovf;

   temp_conv_sequencer_div5_serial u_div (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .start      (div_start),
      .dividend   (prod),
      .done       (div_done),
      .quotient   (div_quo)
   );

   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      f_out_d     = f_out_q;
      f_ovf_d     = f_ovf_q;
      out_valid_d = out_valid_q;
      div_start   = 1'b0;
      prod        = ({4'd0, c_q} << 3) + {4'd0, c_q} + (ROUND ? 12'd2 : 12'd0);
      sum         = div_quo + OFFSET;
      ovf         = (sum > 12'd255);
      case (state_q)
         IDLE: if (bus.in_valid) begin
            c_d     = bus.c_in;
            state_d = MUL;
         end
         MUL: begin
            div_start = 1'b1;
            state_d   = DIV;
         end
         DIV: if (div_done) state_d = ADD;
         ADD: begin
            f_ovf_d     = ovf;
            f_out_d     = (SATURATE && ovf) ? 8'hFF : sum[7:0];
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q     <= IDLE;
         c_q         <= '0;
         f_out_q     <= '0;
         f_ovf_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         f_out_q     <= f_out_d;
         f_ovf_q     <= f_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.f_out     = f_out_q;
   assign bus.f_ovf     = f_ovf_q;

endmodule

// File: tb/tb_temp_conv_sequencer.sv
// Bench: three parameter variants driven in lockstep and checked against an arithmetic model.
module tb_temp_conv_sequencer;

   logic clk_100MHz = 1'b0;
   logic reset      = 1'b1;
   always #5 clk_100MHz = ~clk_100MHz;

   temp_conv_sequencer_if bus_a ();
   temp_conv_sequencer_if bus_b ();
   temp_conv_sequencer_if bus_c ();

   temp_conv_sequencer #(.ROUND(1'b0), .SATURATE(1'b1)) dut_a (
      .clk_100MHz (clk_100MHz), .reset (reset), .bus (bus_a));
   temp_conv_sequencer #(.ROUND(1'b0), .SATURATE(1'b0)) dut_b (
      .clk_100MHz (clk_100MHz), .reset (reset), .bus (bus_b));
   temp_conv_sequencer #(.ROUND(1'b1), .SATURATE(1'b1)) dut_c (
      .clk_100MHz (clk_100MHz), .reset (reset), .bus (bus_c));

   localparam bit RND [3] = '{1'b0, 1'b0, 1'b1};
   localparam bit SAT [3] = '{1'b1, 1'b0, 1'b1};

   logic [8:0] got [3];
   logic       ov  [3];
   logic       ir  [3];
   logic       by  [3];

   assign got[0] = {bus_a.f_ovf, bus_a.f_out};
   assign got[1] = {bus_b.f_ovf, bus_b.f_out};
   assign got[2] = {bus_c.f_ovf, bus_c.f_out};
   assign ov[0]  = bus_a.out_valid;
   assign ov[1]  = bus_b.out_valid;
   assign ov[2]  = bus_c.out_valid;
   assign ir[0]  = bus_a.in_ready;
   assign ir[1]  = bus_b.in_ready;
   assign ir[2]  = bus_c.in_ready;
   assign by[0]  = bus_a.busy;
   assign by[1]  = bus_b.busy;
   assign by[2]  = bus_c.busy;

   int errors = 0;
   int checks = 0;

   // Returns {ovf, f} straight from the formula.
   function automatic logic [8:0] model(input int c, input bit rnd, input bit sat);
      int s;
      bit o;
      s = (c * 9 + (rnd ? 2 : 0)) / 5 + 32;
      o = (s > 255);
      if (sat && o) return {1'b1, 8'hFF};
      return {o, 8'(s % 256)};
   endfunction

   task automatic tick;
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic drive_in(input bit v, input logic [7:0] c);
      bus_a.in_valid = v; bus_a.c_in = c;
      bus_b.in_valid = v; bus_b.c_in = c;
      bus_c.in_valid = v; bus_c.c_in = c;
   endtask

   task automatic drive_ready(input bit r);
      bus_a.out_ready = r;
      bus_b.out_ready = r;
      bus_c.out_ready = r;
   endtask

   task automatic send(input logic [7:0] c);
      int n = 0;
      drive_in(1'b1, c);
      while (ir[0] !== 1'b1 && n < 50) begin
         tick;
         n++;
      end
      tick;
      drive_in(1'b0, c);
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (ov[0] !== 1'b1 && n < 40) begin
         tick;
         n++;
      end
   endtask

   task automatic test_reset;
      drive_in(1'b0, 8'd0);
      drive_ready(1'b0);
      reset = 1'b1;
      repeat (3) tick;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || by[k] !== 1'b0 || got[k] !== 9'd0) begin
            errors++;
            $display("FAIL reset dut%0d: ov=%b ir=%b busy=%b res=%h, want 0 1 0 000", k, ov[k], ir[k], by[k], got[k]);
         end
      end
   endtask

   task automatic test_latency;
      int lat;
      drive_ready(1'b1);
      send(8'd25);
      wait_out(lat);
      checks++;
      if (lat != 14) begin
         errors++;
         $display("FAIL latency: got %0d cycles, want 14", lat);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== model(25, RND[k], SAT[k])) begin
            errors++;
            $display("FAIL c25 dut%0d: got %h want %h", k, got[k], model(25, RND[k], SAT[k]));
         end
      end
      tick;
      checks++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || got[0] !== model(25, 1'b0, 1'b1)) begin
         errors++;
         $display("FAIL post_handshake: ov=%b ir=%b res=%h, want 0 1 %h", ov[0], ir[0], got[0], model(25, 1'b0, 1'b1));
      end
   endtask

   task automatic test_directed;
      int vals [8] = '{0, 100, 124, 125, 255, 1, 26, 37};
      int lat;
      drive_ready(1'b1);
      foreach (vals[i]) begin
         send(8'(vals[i]));
         wait_out(lat);
         checks++;
         if (lat != 14) begin
            errors++;
            $display("FAIL directed_latency c=%0d: got %0d want 14", vals[i], lat);
         end
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got[k] !== model(vals[i], RND[k], SAT[k])) begin
               errors++;
               $display("FAIL directed c=%0d dut%0d: got %h want %h", vals[i], k, got[k], model(vals[i], RND[k], SAT[k]));
            end
         end
         tick;
      end
   endtask

   task automatic test_random;
      logic [7:0] c;
      int lat, hold;
      drive_ready(1'b0);
      for (int t = 0; t < 20; t++) begin
         c    = 8'($urandom);
         hold = int'($urandom_range(0, 5));
         send(c);
         wait_out(lat);
         checks++;
         if (lat != 14) begin
            errors++;
            $display("FAIL random_latency c=%0d: got %0d want 14", c, lat);
         end
         for (int h = 0; h < hold; h++) tick;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || got[k] !== model(int'(c), RND[k], SAT[k])) begin
               errors++;
               $display("FAIL random c=%0d dut%0d: ov=%b res=%h want 1 %h", c, k, ov[k], got[k], model(int'(c), RND[k], SAT[k]));
            end
         end
         drive_ready(1'b1);
         tick;
         drive_ready(1'b0);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] c, pc;
      logic [7:0] q [$];
      int         acc [$];
      logic       pre_ir, pre_hs;
      logic [8:0] pg [3];
      int         nres = 0;
      drive_ready(1'b1);
      c = 8'($urandom);
      drive_in(1'b1, c);
      for (int e = 1; e <= 100; e++) begin
         pre_ir = ir[0];
         pre_hs = ov[0];
         pg     = got;
         tick;
         if (pre_ir) begin
            q.push_back(c);
            acc.push_back(e);
            c = 8'($urandom);
            drive_in(1'b1, c);
         end
         if (pre_hs) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL b2b_spurious: result at edge %0d with nothing in flight", e);
            end else begin
               pc = q.pop_front();
               nres++;
               for (int k = 0; k < 3; k++) begin
                  checks++;
                  if (pg[k] !== model(int'(pc), RND[k], SAT[k])) begin
                     errors++;
                     $display("FAIL b2b c=%0d dut%0d: got %h want %h", pc, k, pg[k], model(int'(pc), RND[k], SAT[k]));
                  end
               end
            end
         end
      end
      checks++;
      if (acc.size() != 7 || nres != 6) begin
         errors++;
         $display("FAIL b2b_count: accepts=%0d results=%0d, want 7 6", acc.size(), nres);
      end
      for (int i = 1; i < acc.size(); i++) begin
         checks++;
         if (acc[i] - acc[i-1] != 16) begin
            errors++;
            $display("FAIL b2b_interval: got %0d cycles want 16", acc[i] - acc[i-1]);
         end
      end
      drive_in(1'b0, 8'd0);
      repeat (20) tick;
      drive_ready(1'b0);
   endtask

   task automatic test_backpressure;
      logic [7:0] a, b;
      int lat;
      a = 8'($urandom);
      b = 8'($urandom);
      drive_ready(1'b0);
      send(a);
      wait_out(lat);
      checks++;
      if (lat != 14) begin
         errors++;
         $display("FAIL bp_latency: got %0d want 14", lat);
      end
      drive_in(1'b1, b);
      for (int i = 0; i < 20; i++) begin
         tick;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b1 || ir[k] !== 1'b0 || got[k] !== model(int'(a), RND[k], SAT[k])) begin
               errors++;
               $display("FAIL bp_hold dut%0d cyc%0d: ov=%b ir=%b res=%h want 1 0 %h", k, i, ov[k], ir[k], got[k], model(int'(a), RND[k], SAT[k]));
            end
         end
      end
      drive_ready(1'b1);
      tick;
      drive_ready(1'b0);
      checks++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: ov=%b ir=%b want 0 1", ov[0], ir[0]);
      end
      tick;
      drive_in(1'b0, b);
      checks++;
      if (ir[0] !== 1'b0 || by[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_second_accept: ir=%b busy=%b want 0 1", ir[0], by[0]);
      end
      wait_out(lat);
      checks++;
      if (lat != 14) begin
         errors++;
         $display("FAIL bp_second_latency: got %0d want 14", lat);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== model(int'(b), RND[k], SAT[k])) begin
            errors++;
            $display("FAIL bp_second dut%0d: got %h want %h", k, got[k], model(int'(b), RND[k], SAT[k]));
         end
      end
      drive_ready(1'b1);
      tick;
      drive_ready(1'b0);
   endtask

   task automatic test_reset_mid;
      int lat;
      drive_ready(1'b1);
      send(8'd200);
      repeat (5) tick;
      checks++;
      if (by[0] !== 1'b1 || ov[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_before_reset: busy=%b ov=%b want 1 0", by[0], ov[0]);
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (ov[k] !== 1'b0 || ir[k] !== 1'b1 || by[k] !== 1'b0 || got[k] !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset dut%0d: ov=%b ir=%b busy=%b res=%h want 0 1 0 000", k, ov[k], ir[k], by[k], got[k]);
         end
      end
      send(8'd37);
      wait_out(lat);
      checks++;
      if (lat != 14) begin
         errors++;
         $display("FAIL mid_latency: got %0d want 14", lat);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got[k] !== model(37, RND[k], SAT[k])) begin
            errors++;
            $display("FAIL mid_c37 dut%0d: got %h want %h", k, got[k], model(37, RND[k], SAT[k]));
         end
      end
      tick;
      drive_ready(1'b0);
   endtask

   initial begin
      drive_in(1'b0, 8'd0);
      drive_ready(1'b0);
      test_reset;
      test_latency;
      test_directed;
      test_random;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
